// File: rtl/rs_alu.sv
// rs_alu: four-entry (parameterisable) reservation station for the integer ALU.
// Entries are kept in a collapsing queue: slot 0 is always the oldest, and the
// valid slots are always contiguous from slot 0. Pending operands wake up from
// the forwarding bus. The oldest fully-ready entry is offered to the ALU.
//
// Handshake: issue_valid_o/issue_* are driven combinationally from registered
// state only. A transfer happens on the rising edge when issue_valid_o and
// issue_ready_i are both 1. While issue_ready_i is 0 the offer is held.
//
// Ports:
//   clk_i, reset_i (async, active low), flush_i (sync clear)
//   dp_*        : dispatch of one renamed instruction (src = data or RRF tag)
//   full_o, count_o : occupancy
//   forward_*   : ALU result forwarding bus (tag + data)
//   issue_*     : valid/ready issue port toward the ALU
module rs_alu #(
  parameter int DATA_LEN  = 32,
  parameter int RRF_SEL   = 6,
  parameter int ENTRY_NUM = 4,
  parameter int ALU_OP_W  = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           flush_i,
  input  logic                           dp_we_i,
  input  logic [DATA_LEN-1:0]            dp_src1_i,
  input  logic                           dp_rdy1_i,
  input  logic [DATA_LEN-1:0]            dp_src2_i,
  input  logic                           dp_rdy2_i,
  input  logic [RRF_SEL-1:0]             dp_rrftag_i,
  input  logic [ALU_OP_W-1:0]            dp_alu_op_i,
  output logic                           full_o,
  output logic [$clog2(ENTRY_NUM):0]     count_o,
  input  logic                           forward_we_i,
  input  logic [RRF_SEL-1:0]             forward_rrftag_i,
  input  logic [DATA_LEN-1:0]            forward_data_i,
  output logic                           issue_valid_o,
  input  logic                           issue_ready_i,
  output logic [DATA_LEN-1:0]            issue_src1_o,
  output logic [DATA_LEN-1:0]            issue_src2_o,
  output logic [RRF_SEL-1:0]             issue_rrftag_o,
  output logic [ALU_OP_W-1:0]            issue_alu_op_o
);

  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int CNT_W = IDX_W + 1;

  logic                valid_q  [ENTRY_NUM];
  logic [DATA_LEN-1:0] src1_q   [ENTRY_NUM];
  logic                rdy1_q   [ENTRY_NUM];
  logic [DATA_LEN-1:0] src2_q   [ENTRY_NUM];
  logic                rdy2_q   [ENTRY_NUM];
  logic [RRF_SEL-1:0]  rrftag_q [ENTRY_NUM];
  logic [ALU_OP_W-1:0] alu_op_q [ENTRY_NUM];
  logic [CNT_W-1:0]    count_q;

  // Slot contents after forward capture, before the collapse
  logic [DATA_LEN-1:0] cap_src1 [ENTRY_NUM];
  logic                cap_rdy1 [ENTRY_NUM];
  logic [DATA_LEN-1:0] cap_src2 [ENTRY_NUM];
  logic                cap_rdy2 [ENTRY_NUM];

  logic                valid_n  [ENTRY_NUM];
  logic [DATA_LEN-1:0] src1_n   [ENTRY_NUM];
  logic                rdy1_n   [ENTRY_NUM];
  logic [DATA_LEN-1:0] src2_n   [ENTRY_NUM];
  logic                rdy2_n   [ENTRY_NUM];
  logic [RRF_SEL-1:0]  rrftag_n [ENTRY_NUM];
  logic [ALU_OP_W-1:0] alu_op_n [ENTRY_NUM];
  logic [CNT_W-1:0]    count_n;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             issue_fire;
  logic             dp_accept;
  logic [CNT_W-1:0] tail;
  logic [DATA_LEN-1:0] dp_src1_eff, dp_src2_eff;
  logic             dp_rdy1_eff, dp_rdy2_eff;

  // Oldest-ready select: scanning downward lets the lowest index win.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (valid_q[i] && rdy1_q[i] && rdy2_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_fire     = sel_found && issue_ready_i;
  assign issue_valid_o  = sel_found;
  assign issue_src1_o   = sel_found ? src1_q[sel_idx]   : '0;
  assign issue_src2_o   = sel_found ? src2_q[sel_idx]   : '0;
  assign issue_rrftag_o = sel_found ? rrftag_q[sel_idx] : '0;
  assign issue_alu_op_o = sel_found ? alu_op_q[sel_idx] : '0;

  assign full_o    = (count_q == CNT_W'(ENTRY_NUM));
  assign count_o   = count_q;
  assign dp_accept = dp_we_i && !full_o && !flush_i;
  // Tail slot as seen after this cycle's collapse
  assign tail      = count_q - CNT_W'(issue_fire);

  // Dispatch bypass: an operand whose producer broadcasts this very cycle
  always_comb begin
    dp_src1_eff = dp_src1_i;
    dp_rdy1_eff = dp_rdy1_i;
    dp_src2_eff = dp_src2_i;
    dp_rdy2_eff = dp_rdy2_i;
    if (!dp_rdy1_i && forward_we_i && dp_src1_i[RRF_SEL-1:0] == forward_rrftag_i) begin
      dp_src1_eff = forward_data_i;
      dp_rdy1_eff = 1'b1;
    end
    if (!dp_rdy2_i && forward_we_i && dp_src2_i[RRF_SEL-1:0] == forward_rrftag_i) begin
      dp_src2_eff = forward_data_i;
      dp_rdy2_eff = 1'b1;
    end
  end

  // Forward capture applied in place; the shift below then carries it along.
  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      cap_src1[i] = src1_q[i];
      cap_rdy1[i] = rdy1_q[i];
      cap_src2[i] = src2_q[i];
      cap_rdy2[i] = rdy2_q[i];
      if (valid_q[i] && !rdy1_q[i] && forward_we_i &&
          src1_q[i][RRF_SEL-1:0] == forward_rrftag_i) begin
        cap_src1[i] = forward_data_i;
        cap_rdy1[i] = 1'b1;
      end
      if (valid_q[i] && !rdy2_q[i] && forward_we_i &&
          src2_q[i][RRF_SEL-1:0] == forward_rrftag_i) begin
        cap_src2[i] = forward_data_i;
        cap_rdy2[i] = 1'b1;
      end
    end
  end

  // Next state: collapse over the issued slot, then append at the tail.
  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      valid_n[i]  = valid_q[i];
      src1_n[i]   = cap_src1[i];
      rdy1_n[i]   = cap_rdy1[i];
      src2_n[i]   = cap_src2[i];
      rdy2_n[i]   = cap_rdy2[i];
      rrftag_n[i] = rrftag_q[i];
      alu_op_n[i] = alu_op_q[i];
    end
    for (int i = 0; i < ENTRY_NUM - 1; i++) begin
      if (issue_fire && i >= int'(sel_idx)) begin
        valid_n[i]  = valid_q[i+1];
        src1_n[i]   = cap_src1[i+1];
        rdy1_n[i]   = cap_rdy1[i+1];
        src2_n[i]   = cap_src2[i+1];
        rdy2_n[i]   = cap_rdy2[i+1];
        rrftag_n[i] = rrftag_q[i+1];
        alu_op_n[i] = alu_op_q[i+1];
      end
    end
    if (issue_fire) begin
      valid_n[ENTRY_NUM-1] = 1'b0;
    end
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (dp_accept && CNT_W'(i) == tail) begin
        valid_n[i]  = 1'b1;
        src1_n[i]   = dp_src1_eff;
        rdy1_n[i]   = dp_rdy1_eff;
        src2_n[i]   = dp_src2_eff;
        rdy2_n[i]   = dp_rdy2_eff;
        rrftag_n[i] = dp_rrftag_i;
        alu_op_n[i] = dp_alu_op_i;
      end
    end
    count_n = count_q - CNT_W'(issue_fire) + CNT_W'(dp_accept);
    if (flush_i) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        valid_n[i] = 1'b0;
      end
      count_n = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        valid_q[i]  <= 1'b0;
        src1_q[i]   <= '0;
        rdy1_q[i]   <= 1'b0;
        src2_q[i]   <= '0;
        rdy2_q[i]   <= 1'b0;
        rrftag_q[i] <= '0;
        alu_op_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        valid_q[i]  <= valid_n[i];
        src1_q[i]   <= src1_n[i];
        rdy1_q[i]   <= rdy1_n[i];
        src2_q[i]   <= src2_n[i];
        rdy2_q[i]   <= rdy2_n[i];
        rrftag_q[i] <= rrftag_n[i];
        alu_op_q[i] <= alu_op_n[i];
      end
      count_q <= count_n;
    end
  end

endmodule
